// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

  localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/clk_div_prog.sv
// Fully synchronous programmable divider: one counter, a shadow register for
// runtime divisor/mode updates applied at period boundaries, registered outputs.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_RST = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             mode_i,
  input  logic             div_load_i,
  output logic             div_pend_o,
  output logic             div_ack_o,
  output logic             div_err_o,
  output logic             tick_o,
  output logic             out_o
);

  if ((DIV_RST < DIV_MIN) || (DIV_RST > (2 ** DIV_W) - 1)) begin : g_bad_div_rst
    $error("clk_div_prog: DIV_RST out of range");
  end

  localparam logic [DIV_W-1:0] DivMin   = DIV_W'(DIV_MIN);
  localparam logic [DIV_W-1:0] DivReset = DIV_W'(DIV_RST);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_q, n_d;
  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] sh_n_q, sh_n_d;
  mode_e            sh_mode_q, sh_mode_d;
  logic             pend_q, pend_d;
  logic             ack_q, err_q, tick_q;
  logic             out_q, out_d;

  logic             wrap, apply, load_bad, load_ok;
  logic [DIV_W:0]   half;

  always_comb begin
    wrap      = en_i && (cnt_q == n_q - DIV_W'(1));
    // Pending request lands on a wrap, or immediately while the counter is idle.
    apply     = pend_q && (wrap || !en_i);
    load_bad  = div_load_i && (div_i < DivMin);
    load_ok   = div_load_i && !pend_q && !load_bad;

    cnt_d     = cnt_q;
    n_d       = n_q;
    mode_d    = mode_q;
    sh_n_d    = sh_n_q;
    sh_mode_d = sh_mode_q;
    pend_d    = pend_q;
    out_d     = out_q;

    if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + DIV_W'(1);
    end

    if (apply) begin
      n_d    = sh_n_q;
      mode_d = sh_mode_q;
      pend_d = 1'b0;
      if (!en_i) begin
        cnt_d = '0;
      end
    end else if (load_ok) begin
      sh_n_d    = div_i;
      sh_mode_d = mode_e'(mode_i);
      pend_d    = 1'b1;
    end

    // High phase is ceil(N/2); widened so N = 2^DIV_W-1 cannot overflow.
    half = ({1'b0, n_d} + (DIV_W + 1)'(1)) >> 1;

    if (en_i) begin
      out_d = (mode_d == MODE_PULSE) ? wrap : ({1'b0, cnt_d} < half);
    end else if (apply) begin
      out_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      n_q       <= DivReset;
      mode_q    <= MODE_SQUARE;
      sh_n_q    <= '0;
      sh_mode_q <= MODE_SQUARE;
      pend_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tick_q    <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      mode_q    <= mode_d;
      sh_n_q    <= sh_n_d;
      sh_mode_q <= sh_mode_d;
      pend_q    <= pend_d;
      ack_q     <= apply;
      err_q     <= load_bad;
      tick_q    <= wrap;
      out_q     <= out_d;
    end
  end

  assign div_pend_o = pend_q;
  assign div_ack_o  = ack_q;
  assign div_err_o  = err_q;
  assign tick_o     = tick_q;
  assign out_o      = out_q;

endmodule
